// File: rtl/cmd_parser_pkg.sv
// cmd_pkg: shared definitions for the ASCII command parser.
//   cmd_t      - command codes handed to the coprocessor (CMD_NONE = nothing pending)
//   state_t    - parser states
//   MN_*       - two-character mnemonics, first character in the upper byte
//   lookup_cmd - maps a two-byte mnemonic to its command, CMD_NONE on a miss
package cmd_pkg;

    localparam int CMD_CODE_W = 3;

    typedef enum logic [CMD_CODE_W-1:0] {
        CMD_NONE   = 3'd0,
        CMD_READ_A = 3'd1,
        CMD_READ_B = 3'd2,
        CMD_SUM    = 3'd3,
        CMD_AVG    = 3'd4,
        CMD_CLEAR  = 3'd5
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        EXEC
    } state_t;

    localparam logic [15:0] MN_READ_A = "ra";
    localparam logic [15:0] MN_READ_B = "rb";
    localparam logic [15:0] MN_SUM    = "su";
    localparam logic [15:0] MN_AVG    = "av";
    localparam logic [15:0] MN_CLEAR  = "cl";

    function automatic cmd_t lookup_cmd(input logic [7:0] first, input logic [7:0] second);
        case ({first, second})
            MN_READ_A: return CMD_READ_A;
            MN_READ_B: return CMD_READ_B;
            MN_SUM:    return CMD_SUM;
            MN_AVG:    return CMD_AVG;
            MN_CLEAR:  return CMD_CLEAR;
            default:   return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cmd_parser_timeout.sv
// cmd_timeout: inter-byte idle counter.
//   clk, rst  - clock, synchronous active-high reset
//   enable    - count only while high; the counter is held at 0 otherwise
//   restart   - a byte was accepted this cycle; counter restarts, no expiry
//   expire    - one-cycle pulse in the TIMEOUT_CYCLES-th consecutive idle cycle
// TIMEOUT_CYCLES = 0 disables the block (expire never fires).
module cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [CW-1:0] count;

    // The count holds the number of idle cycles already seen, so the cycle in
    // which it shows TIMEOUT_CYCLES-1 is the last one of the idle window.
    assign expire = (TIMEOUT_CYCLES != 0) && enable && !restart && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || !enable || restart || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// cmd_parser: collects UART bytes into a two-character mnemonic, decodes it on
// the terminator and offers the command to the coprocessor.
//   clk, rst          - clock, synchronous active-high reset
//   rx_byte, rx_valid - received byte and its one-cycle strobe
//   coprocessor_busy  - coprocessor is executing the accepted command
//   cmd_ready         - coprocessor takes the offered command this cycle
//   cmd, cmd_valid    - decoded command and its valid flag (CMD_NONE when idle)
//   cmd_error         - one-cycle pulse on a malformed line or a timeout flush
//   overrun           - sticky: a byte arrived while not in IDLE and was dropped
module cmd_parser
    import cmd_pkg::*;
#(
    parameter logic [7:0]  TERM           = 8'h0A,
    parameter bit          IGNORE_CR      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int          CMD_W          = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             coprocessor_busy,
    input  logic             cmd_ready,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             cmd_error,
    output logic             overrun
);

    state_t     state;
    state_t     state_next;
    cmd_t       cmd_q;
    cmd_t       match;
    logic [7:0] buf0;
    logic [7:0] buf1;
    logic [1:0] cnt;
    logic       guard;
    logic       err_q;
    logic       overrun_q;
    logic       byte_in;
    logic       accept;
    logic       is_term;
    logic       term_hit;
    logic       term_bad;
    logic       expire;

    // An ignored CR is invisible to the parser: it neither fills the buffer
    // nor restarts the idle counter.
    assign byte_in  = rx_valid && !(IGNORE_CR && (rx_byte == 8'h0D));
    assign accept   = (state == IDLE) && byte_in;
    assign is_term  = (rx_byte == TERM);
    assign match    = lookup_cmd(buf0, buf1);
    assign term_hit = accept && is_term && (cnt == 2'd2) && (match != CMD_NONE);
    assign term_bad = accept && is_term && (cnt != 2'd0) && !term_hit;

    cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .enable ((state == IDLE) && (cnt != 2'd0)),
        .restart(accept),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // guard marks the first EXEC cycle, where busy may not yet reflect the
    // command that was just handed over.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (term_hit) state_next = ISSUE;
            ISSUE:   if (cmd_ready) state_next = EXEC;
            EXEC:    if (!guard && !coprocessor_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = 1'b0;
        cmd       = CMD_W'(CMD_NONE);
        case (state)
            ISSUE: begin
                cmd_valid = 1'b1;
                cmd       = CMD_W'(cmd_q);
            end
            EXEC:    cmd = CMD_W'(cmd_q);
            default: ;
        endcase
    end

    assign cmd_error = err_q;
    assign overrun   = overrun_q;

    // cnt saturates at 3 so an over-long mnemonic is remembered until the
    // terminator without storing the extra bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0      <= '0;
            buf1      <= '0;
            cnt       <= '0;
            guard     <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            cmd_q     <= CMD_NONE;
        end else begin
            err_q <= term_bad || expire;
            guard <= (state == ISSUE) && cmd_ready;
            if (rx_valid && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
            if (term_hit) begin
                cmd_q <= match;
            end
            if (accept) begin
                if (is_term) begin
                    cnt <= 2'd0;
                end else begin
                    case (cnt)
                        2'd0: begin
                            buf0 <= rx_byte;
                            cnt  <= 2'd1;
                        end
                        2'd1: begin
                            buf1 <= rx_byte;
                            cnt  <= 2'd2;
                        end
                        2'd2:    cnt <= 2'd3;
                        default: ;
                    endcase
                end
            end else if (expire) begin
                cnt <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_parser.sv
// tb_cmd_parser: directed bench for cmd_parser with a line-level reference
// model (byte queue + mnemonic table) compared every cycle, plus literal
// expectations for each scenario.
module tb_cmd_parser;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_valid = 1'b0;
    logic       coprocessor_busy = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_error;
    logic       overrun;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    cmd_parser #(
        .TERM          (8'h0A),
        .IGNORE_CR     (1'b1),
        .TIMEOUT_CYCLES(TMO),
        .CMD_W         (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_byte         (rx_byte),
        .rx_valid        (rx_valid),
        .coprocessor_busy(coprocessor_busy),
        .cmd_ready       (cmd_ready),
        .cmd             (cmd),
        .cmd_valid       (cmd_valid),
        .cmd_error       (cmd_error),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = collecting text, 1 = command offered,
    // 2 = command handed over and running.
    int          codes[string];
    byte unsigned line[$];
    string       m_key;
    int          m_phase = 0;
    int          m_exec_n = 0;
    int          m_idle = 0;
    int          m_cmd = 0;
    bit          m_err = 1'b0;
    bit          m_ovr = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            line.delete();
            m_phase = 0;
            m_exec_n = 0;
            m_idle = 0;
            m_cmd = 0;
            m_err = 1'b0;
            m_ovr = 1'b0;
        end else begin
            m_err = 1'b0;
            case (m_phase)
                0: begin
                    if (rx_valid && rx_byte == 8'h0A) begin
                        if (line.size() == 2) begin
                            m_key = $sformatf("%c%c", line[0], line[1]);
                            if (codes.exists(m_key)) begin
                                m_cmd = codes[m_key];
                                m_phase = 1;
                            end else begin
                                m_err = 1'b1;
                            end
                        end else if (line.size() != 0) begin
                            m_err = 1'b1;
                        end
                        line.delete();
                        m_idle = 0;
                    end else if (rx_valid && rx_byte != 8'h0D) begin
                        if (line.size() < 3) line.push_back(rx_byte);
                        m_idle = 0;
                    end else if (line.size() != 0) begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            line.delete();
                            m_err = 1'b1;
                            m_idle = 0;
                        end
                    end
                end
                1: begin
                    if (rx_valid) m_ovr = 1'b1;
                    if (cmd_ready) begin
                        m_phase = 2;
                        m_exec_n = 0;
                    end
                end
                default: begin
                    if (rx_valid) m_ovr = 1'b1;
                    m_exec_n++;
                    if (m_exec_n >= 2 && !coprocessor_busy) begin
                        m_phase = 0;
                        m_cmd = 0;
                    end
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_cmd", 32'(cmd), 32'(m_cmd));
            checkOutput("model_valid", 32'(cmd_valid), 32'(m_phase == 1));
            checkOutput("model_error", 32'(cmd_error), 32'(m_err));
            checkOutput("model_overrun", 32'(overrun), 32'(m_ovr));
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic rdy, input logic bsy);
        @(negedge clk);
        rx_valid = v;
        rx_byte = b;
        cmd_ready = rdy;
        coprocessor_busy = bsy;
    endtask

    task automatic sendText(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) begin
            applyStimulus(1'b1, s[i], rdy, 1'b0);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        codes["ra"] = 1;
        codes["rb"] = 2;
        codes["su"] = 3;
        codes["av"] = 4;
        codes["cl"] = 5;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_cmd", 32'(cmd), 0);
        checkOutput("reset_valid", 32'(cmd_valid), 0);
        checkOutput("reset_error", 32'(cmd_error), 0);
        checkOutput("reset_overrun", 32'(overrun), 0);
        check_en = 1'b1;
        rst = 1'b0;

        // "ra\n", ready high, busy for 4 cycles
        sendText("ra\n", 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("ra_valid", 32'(cmd_valid), 1);
        checkOutput("ra_cmd", 32'(cmd), 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("ra_guard_valid", 32'(cmd_valid), 0);
        checkOutput("ra_guard_cmd", 32'(cmd), 1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("ra_exec_hold", 32'(cmd), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("ra_back_idle", 32'(cmd), 0);

        // "su\n", ready held low for 5 cycles
        sendText("su\n", 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("su_wait_valid", 32'(cmd_valid), 1);
            checkOutput("su_wait_cmd", 32'(cmd), 3);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("su_hs_valid", 32'(cmd_valid), 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("su_guard_valid", 32'(cmd_valid), 0);
        checkOutput("su_guard_cmd", 32'(cmd), 3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("su_exec2_cmd", 32'(cmd), 3);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("su_back_idle", 32'(cmd), 0);

        // malformed lines
        sendText("xy\n", 1'b0);
        idleCycles(1);
        checkOutput("xy_error", 32'(cmd_error), 1);
        checkOutput("xy_valid", 32'(cmd_valid), 0);
        idleCycles(1);
        checkOutput("xy_error_once", 32'(cmd_error), 0);
        sendText("rab\n", 1'b0);
        idleCycles(1);
        checkOutput("rab_error", 32'(cmd_error), 1);
        idleCycles(1);
        checkOutput("rab_error_once", 32'(cmd_error), 0);
        sendText("r\n", 1'b0);
        idleCycles(1);
        checkOutput("r_error", 32'(cmd_error), 1);
        idleCycles(1);
        sendText("\n", 1'b0);
        idleCycles(1);
        checkOutput("bare_lf_no_error", 32'(cmd_error), 0);

        // CR inside the mnemonic is skipped
        applyStimulus(1'b1, "r", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h0D, 1'b1, 1'b0);
        applyStimulus(1'b1, "a", 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h0A, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("cr_cmd", 32'(cmd), 1);
        checkOutput("cr_valid", 32'(cmd_valid), 1);
        idleCycles(3);
        checkOutput("cr_back_idle", 32'(cmd), 0);

        // byte during EXEC sets overrun and is not buffered
        sendText("cl\n", 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("cl_cmd", 32'(cmd), 5);
        applyStimulus(1'b1, "a", 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("cl_overrun", 32'(overrun), 1);
        idleCycles(2);
        checkOutput("cl_back_idle", 32'(cmd), 0);
        sendText("av\n", 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("av_cmd", 32'(cmd), 4);
        checkOutput("av_overrun_sticky", 32'(overrun), 1);
        idleCycles(3);

        // timeout flush of a partial buffer
        applyStimulus(1'b1, "r", 1'b0, 1'b0);
        for (int i = 0; i < TMO; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
            checkOutput("tmo_no_early_error", 32'(cmd_error), 0);
        end
        idleCycles(1);
        checkOutput("tmo_error", 32'(cmd_error), 1);
        idleCycles(1);
        checkOutput("tmo_error_once", 32'(cmd_error), 0);
        sendText("b\n", 1'b0);
        idleCycles(1);
        checkOutput("tmo_b_error", 32'(cmd_error), 1);
        checkOutput("tmo_b_valid", 32'(cmd_valid), 0);
        idleCycles(1);

        // reset while offering a command
        sendText("ra\n", 1'b0);
        idleCycles(1);
        checkOutput("rst_pre_valid", 32'(cmd_valid), 1);
        rst = 1'b1;
        idleCycles(1);
        checkOutput("rst_valid", 32'(cmd_valid), 0);
        checkOutput("rst_cmd", 32'(cmd), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        sendText("rb\n", 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rb_cmd", 32'(cmd), 2);
        idleCycles(3);
        checkOutput("rb_back_idle", 32'(cmd), 0);

        @(negedge clk);
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
Parametrised ASCII command parser between the UART receiver and the coprocessor.
- Collects received bytes into a mnemonic buffer and matches terminated mnemonics against a command table of SUM, AVG and CLEAR, as well as the read commands.
- Issues the decoded command with a valid/ready handshake, then holds it until the coprocessor finishes.
- Flags malformed input, dropped bytes and stale partial input after an inter-byte timeout.

Parameters:
- TERM, 8'h0A: terminator byte (LF).
- IGNORE_CR, 1: when 1, byte 8'h0D is discarded without affecting the buffer or the timeout.
- TIMEOUT_CYCLES, 1_000_000: idle clk cycles after which a partial buffer is flushed; 0 disables the timeout.
- CMD_W, 3: command code width; must be wide enough for every code in the package.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- rx_byte, in, 8: received byte; valid only when rx_valid=1.
- rx_valid, in, 1: one-cycle strobe per received byte.
- coprocessor_busy, in, 1: high while the coprocessor executes a command.
- cmd_ready, in, 1: coprocessor accepts the command in this cycle.
- cmd, out, CMD_W: decoded command; CMD_NONE when no command is pending.
- cmd_valid, out, 1: command offered to the coprocessor.
- cmd_error, out, 1: one-cycle pulse on a malformed command or a timeout flush.
- overrun, out, 1: sticky; a byte was dropped because the parser was not in IDLE.

Behaviour:
- Reset values: cmd=CMD_NONE, cmd_valid=0, cmd_error=0, overrun=0, state=IDLE, buffer empty (cnt=0), timeout counter=0.
- Buffer: two 8-bit registers holding the first and second non-terminator bytes, plus a count cnt (0..3) that saturates at 3.
- The buffer is only written in IDLE, on rx_valid with a byte that is neither TERM nor an ignored CR.
  - cnt=0: byte goes to the first register.
  - cnt=1: byte goes to the second register.
  - cnt=2: no register write; cnt becomes 3, marking the mnemonic too long.
- Terminator handling in IDLE (rx_valid with rx_byte=TERM):
  - cnt=0: ignored silently; no error.
  - cnt=2 and the buffer matches a table entry: latch cmd, go to ISSUE next cycle.
  - Any other case (cnt=1, cnt=3, or no table match): cmd_error pulses in the next cycle; state stays IDLE.
  - The buffer is cleared on every terminator.
- Latency: a terminator accepted in cycle N gives cmd_valid=1 and a valid cmd in cycle N+1.
- State machine:
  - IDLE: cmd=CMD_NONE, cmd_valid=0.
  - ISSUE: cmd_valid=1; cmd stays stable until the handshake. The handshake completes in the first cycle with cmd_valid and cmd_ready both high; the next state is EXEC.
  - EXEC: cmd_valid=0; cmd holds its value. The first EXEC cycle is a guard cycle in which busy is ignored. From the second EXEC cycle on, coprocessor_busy=0 returns the parser to IDLE and sets cmd=CMD_NONE.
- Bytes arriving in ISSUE or EXEC are dropped and set overrun. overrun is cleared only by rst.
- Timeout: applies only when TIMEOUT_CYCLES>0, in IDLE with cnt>0.
  - The counter increments each cycle without an accepted byte and restarts on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, the buffer is cleared, cmd_error pulses once and the counter resets.
  - The counter is held at 0 when cnt=0 or when not in IDLE.
- Simultaneous events:
  - rx_valid in the last ISSUE cycle (the handshake cycle): the byte is dropped and overrun is set.
  - Timeout expiry and rx_valid in the same cycle: the byte wins; the counter restarts and no error is raised.
- Reset mid-operation: returns to IDLE within one cycle and cmd_valid drops. The coprocessor handles any command already accepted independently.

Decomposition:
- Package cmd_pkg holds:
  - cmd_t enum (CMD_W bits): CMD_NONE=0, CMD_READ_A=1 ("ra"), CMD_READ_B=2 ("rb"), CMD_SUM=3 ("su"), CMD_AVG=4 ("av"), CMD_CLEAR=5 ("cl").
  - The mnemonic constants.
  - A lookup function mapping two bytes to cmd_t, returning CMD_NONE on a miss.
  - The parser state enum: IDLE, ISSUE, EXEC.
- Sub-module cmd_timeout: idle counter with restart, enable and expire-pulse ports, parametrised by TIMEOUT_CYCLES.

Test Plan:
- "ra\n" with cmd_ready=1, then busy high for 4 cycles -> cmd_valid=1 for exactly 1 cycle starting 1 cycle after LF, cmd=1; the parser returns to IDLE on the first cycle busy=0 after the guard cycle.
- "su\n" with cmd_ready held low for 5 cycles -> cmd_valid=1 and cmd=3 stable for 6 cycles; moves to EXEC after the handshake cycle.
- "xy\n", then "rab\n", then "r\n" -> three single-cycle cmd_error pulses; cmd_valid stays 0; a bare "\n" produces no pulse; "r\r a\n" with IGNORE_CR=1 is treated as "ra\n" (cmd=1).
- "cl\n" followed by the byte 'a' during EXEC -> overrun=1 and stays 1; the byte does not appear in the buffer; a later "av\n" decodes to cmd=4.
- TIMEOUT_CYCLES=16: send "r", wait 16 cycles -> one cmd_error pulse; a following "b\n" gives an error (cnt=1), not READ_B.
- Assert rst during ISSUE -> the next cycle shows cmd_valid=0, cmd=0 and overrun=0; a subsequent "rb\n" decodes to cmd=2.
